// File: rtl/data_mem_responder.sv
// Data-port responder for a single-cycle core: word RAM, free-running cycle
// counter and a transmit FIFO behind a full 32-bit address decoder.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam int unsigned PW          = $clog2(FIFO_DEPTH);
  localparam logic [32:0] RAM_LIMIT   = 33'(DEPTH_WORDS) << 2;
  localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE;
  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'd4;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'd8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYCLE,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram [DEPTH_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [31:0]   cycle;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          overflow_set;
  logic          status_wr;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel = SEL_NONE;
    if ({1'b0, address_to_mem} < RAM_LIMIT)                  sel = SEL_RAM;
    else if (address_to_mem[31:2] == CYCLE_ADDR[31:2])       sel = SEL_CYCLE;
    else if (address_to_mem[31:2] == TXDATA_ADDR[31:2])      sel = SEL_TXDATA;
    else if (address_to_mem[31:2] == STATUS_ADDR[31:2])      sel = SEL_STATUS;
  end

  assign ram_idx = address_to_mem[AW+1:2];

  assign empty        = (count == '0);
  assign full         = (count == (PW+1)'(FIFO_DEPTH));
  assign pop          = !empty && tx_ready;
  assign push_req     = WE && (sel == SEL_TXDATA);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push         = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;
  assign status_wr    = WE && (sel == SEL_STATUS);

  assign tx_valid = !empty;
  assign tx_data  = empty ? 32'h0 : fifo_mem[rd_ptr];

  // NOTE: storage arrays carry no reset; only the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (WE && (sel == SEL_RAM)) ram[ram_idx] <= data_to_mem;
    if (push)                   fifo_mem[wr_ptr] <= data_to_mem;
  end

  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cycle    <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
      if (overflow_set)   overflow <= 1'b1;
      else if (status_wr) overflow <= 1'b0;
    end
  end

  always_comb begin
    data_from_mem = '0;
    case (sel)
      SEL_RAM:    data_from_mem = ram[ram_idx];
      SEL_CYCLE:  data_from_mem = cycle;
      SEL_STATUS: data_from_mem = {29'b0, overflow, full, empty};
      default:    data_from_mem = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder, checked against a
// queue/array reference model of the memory map.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC = BASE;
  localparam logic [31:0] A_TX  = BASE + 32'd4;
  localparam logic [31:0] A_ST  = BASE + 32'd8;
  localparam logic [31:0] A_UNM = BASE + 32'hC;
  localparam int          QMAX  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [256];
  bit          m_wr  [256];
  logic [31:0] m_q [$];
  bit          m_ovf;
  logic [31:0] m_cycle;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .WE             (WE),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a < 32'd1024) begin
      v = m_ram[int'(a >> 2)];
      return m_wr[int'(a >> 2)];
    end
    if ((a & ~32'h3) == A_CYC)     v = m_cycle;
    else if ((a & ~32'h3) == A_ST) v = {29'b0, m_ovf, m_q.size() == QMAX, m_q.size() == 0};
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_cycle = 32'h0;
  endfunction

  function automatic void model_edge();
    logic [31:0] a;
    if (!reset) return;
    a = address_to_mem & ~32'h3;
    if (tx_ready && m_q.size() != 0) void'(m_q.pop_front());
    if (WE && a == A_ST) m_ovf = 1'b0;
    if (WE && a == A_TX) begin
      if (m_q.size() < QMAX) m_q.push_back(data_to_mem);
      else                   m_ovf = 1'b1;
    end
    if (WE && address_to_mem < 32'd1024) begin
      m_ram[int'(address_to_mem >> 2)] = data_to_mem;
      m_wr[int'(address_to_mem >> 2)]  = 1'b1;
    end
    m_cycle = m_cycle + 32'd1;
  endfunction

  // One clock cycle: drive, check combinational outputs against the model, take the edge.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input string tag);
    logic [31:0] v;
    WE = we; address_to_mem = a; data_to_mem = d; tx_ready = rdy;
    #1;
    if (model_read(a, v)) check({tag, "_rd"}, data_from_mem, v);
    check({tag, "_valid"}, {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
    check({tag, "_txdata"}, tx_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
    WE = 1'b0; address_to_mem = a;
    #1;
    check(tag, data_from_mem, exp);
  endtask

  initial begin
    logic [31:0] drain_exp [4];
    int          guard;
    logic [31:0] a;

    reset = 1'b0; WE = 1'b0; address_to_mem = '0; data_to_mem = '0; tx_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_txdata", tx_data, 32'h0);
    peek(A_ST, 32'h1, "rst_status");
    peek(A_CYC, 32'h0, "rst_cycle");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Counter after release
    cyc(1'b0, A_CYC, 32'h0, 1'b0, "cyc0");
    for (int i = 1; i <= 3; i++) begin
      peek(A_CYC, 32'(i), "cycle_seq");
      cyc(1'b0, A_CYC, 32'h0, 1'b0, "cyc");
    end
    cyc(1'b1, A_CYC, 32'h55, 1'b0, "cyc_wr");
    peek(A_CYC, 32'd5, "cycle_after_wr");

    // RAM
    cyc(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, "ram_wr0");
    cyc(1'b1, 32'h3FC, 32'hCAFE_F00D, 1'b0, "ram_wr1");
    peek(32'h10, 32'hDEAD_BEEF, "ram_rd0");
    peek(32'h3FC, 32'hCAFE_F00D, "ram_rd1");
    peek(32'h13, 32'hDEAD_BEEF, "ram_rd_unaligned");
    peek(32'h400, 32'h0, "ram_past_end");
    cyc(1'b1, 32'h10, 32'h1111_2222, 1'b0, "ram_same_cycle");
    peek(32'h10, 32'h1111_2222, "ram_next_cycle");

    // FIFO fill, overflow, drain
    for (int i = 1; i <= 4; i++) cyc(1'b1, A_TX, 32'(i), 1'b0, "fill");
    peek(A_ST, 32'h2, "status_full");
    check("valid_full", {31'b0, tx_valid}, 32'h1);
    cyc(1'b1, A_TX, 32'd5, 1'b0, "push_over");
    peek(A_ST, 32'h6, "status_overflow");
    for (int i = 1; i <= 4; i++) begin
      check("drain", tx_data, 32'(i));
      cyc(1'b0, A_ST, 32'h0, 1'b1, "drain_cyc");
    end
    tx_ready = 1'b0;
    peek(A_ST, 32'h5, "status_drained");
    cyc(1'b1, A_ST, $urandom, 1'b0, "status_wr");
    peek(A_ST, 32'h1, "status_cleared");

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) cyc(1'b1, A_TX, 32'(i), 1'b0, "fill2");
    cyc(1'b1, A_TX, 32'd9, 1'b1, "push_pop_full");
    peek(A_ST, 32'h2, "status_push_pop");
    drain_exp = '{32'd2, 32'd3, 32'd4, 32'd9};
    for (int i = 0; i < 4; i++) begin
      check("drain2", tx_data, drain_exp[i]);
      cyc(1'b0, A_ST, 32'h0, 1'b1, "drain2_cyc");
    end
    peek(A_ST, 32'h1, "status_empty2");

    // Unmapped address
    cyc(1'b1, A_UNM, 32'h1234, 1'b0, "unmapped_wr");
    peek(A_UNM, 32'h0, "unmapped_rd");
    peek(A_ST, 32'h1, "unmapped_status");
    peek(32'h10, 32'h1111_2222, "unmapped_ram");

    // Asynchronous reset mid-stream
    cyc(1'b1, A_TX, 32'hA, 1'b0, "q3a");
    cyc(1'b1, A_TX, 32'hB, 1'b0, "q3b");
    cyc(1'b1, A_TX, 32'hC, 1'b0, "q3c");
    guard = 0;
    while (m_cycle < 32'd50 && guard < 200) begin
      cyc(1'b0, A_CYC, 32'h0, 1'b0, "idle");
      guard++;
    end
    check("cycle_reached_50", {31'b0, m_cycle >= 32'd50}, 32'h1);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid", {31'b0, tx_valid}, 32'h0);
    check("async_rst_txdata", tx_data, 32'h0);
    peek(A_ST, 32'h1, "async_rst_status");
    peek(A_CYC, 32'h0, "async_rst_cycle");
    peek(32'h3FC, 32'hCAFE_F00D, "async_rst_ram");
    cyc(1'b1, A_TX, 32'h77, 1'b1, "in_reset0");
    cyc(1'b0, A_CYC, 32'h0, 1'b1, "in_reset1");
    reset = 1'b1;
    cyc(1'b0, A_CYC, 32'h0, 1'b0, "release");
    peek(A_CYC, 32'h1, "cycle_after_release");
    peek(32'h10, 32'h1111_2222, "ram_after_reset");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic rdy;
      int   idx;
      rdy = ($urandom_range(0, 2) == 0);
      idx = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 15));
      case ($urandom_range(0, 6))
        0: cyc(1'b1, 32'(idx * 4 + int'($urandom_range(0, 3))), $urandom, rdy, "r_ramwr");
        1: cyc(1'b0, 32'(idx * 4 + int'($urandom_range(0, 3))), 32'h0, rdy, "r_ramrd");
        2: cyc(1'b1, A_TX, $urandom, rdy, "r_push");
        3: cyc(1'b1, A_ST, $urandom, rdy, "r_stwr");
        4: cyc(1'b0, ($urandom_range(0, 1) != 0) ? A_ST : A_CYC, 32'h0, rdy, "r_mmiord");
        5: begin
          a = ($urandom_range(0, 1) != 0) ? (A_UNM + 32'($urandom_range(0, 64))) : (32'h400 + $urandom_range(0, 4096));
          cyc(1'b1, a, $urandom, rdy, "r_unmapped");
        end
        default: cyc(1'b0, A_TX, 32'h0, rdy, "r_idle");
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the single-cycle processor's data port. It returns `data_from_mem` combinationally in the same cycle as `address_to_mem`, and commits stores on the rising clock edge. Behind the address decoder sit three things: a word-organised data RAM, a free-running cycle counter and a transmit FIFO. The FIFO drains stored words to a downstream consumer over a valid/ready stream. The block connects directly to the processor's `WE`, `address_to_mem`, `data_to_mem` and `data_from_mem`.

## Interface
- `DEPTH_WORDS`, 256: RAM size in 32-bit words; power of two, ≥ 2.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥ 2.
- `MMIO_BASE`, 32'hFFFF_0000: base address of the register window.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `WE`  in  1  store strobe from the processor.
- `address_to_mem`  in  32  byte address from the processor.
- `data_to_mem`  in  32  store data from the processor.
- `data_from_mem`  out  32  load data to the processor; combinational.
- `tx_data`  out  32  FIFO head word.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts `tx_data` on this edge.

## Operation
- Decode uses the full 32-bit address. Bits [1:0] are ignored everywhere, so accesses are word-only.
  - RAM: `address_to_mem < 4*DEPTH_WORDS`. Word index is `address_to_mem[log2(DEPTH_WORDS)+1:2]`.
  - CYCLE: `MMIO_BASE+0`.
  - TXDATA: `MMIO_BASE+4`.
  - STATUS: `MMIO_BASE+8`.
  - Any other address is unmapped: reads return 0 and writes are ignored.
- RAM:
  - Read is asynchronous.
  - Write stores `data_to_mem` at the edge when `WE`=1.
  - Contents are not cleared by reset.
- CYCLE:
  - 32-bit counter that increments every cycle out of reset and wraps FFFF_FFFF→0.
  - Read returns the current (pre-increment) value.
  - Writes are ignored.
- TXDATA:
  - A write pushes `data_to_mem` into the FIFO.
  - Reads return 0.
- STATUS:
  - Read returns `{29'b0, overflow, full, empty}`.
  - Any write clears `overflow`, whatever the data.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - `tx_valid` = (count≠0).
  - `tx_data` = entry at the read pointer. It is 0 when empty.
  - Pop on an edge with `tx_valid`&`tx_ready`.
  - Push on an edge with `WE` and address=TXDATA.
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous events:
  - Push and pop together: both take effect and count is unchanged. This holds when full, because the freed slot is reused in the same edge.
  - Push while full with no pop: the word is dropped, `overflow` is set (sticky) and the FIFO is unchanged.
  - Pop while empty: no effect.
  - STATUS write coinciding with an overflowing push: set wins and `overflow` stays 1.
- `tx_ready` while `tx_valid`=0 is a legal no-op.

## Timing
- Load latency is 0 cycles: `data_from_mem` is valid combinationally from `address_to_mem`. This is required by the processor's single-cycle `lw`.
- Stores, pushes, pops and the CYCLE increment all take effect at the same rising edge.
- A read of STATUS or FIFO state in the cycle after a push or pop shows the updated value.
- A read of the same RAM word in the cycle after a store returns the new data. A read in the same cycle as the store returns the old data.
- Reset asserted (asynchronous, at any time including mid-stream):
  - count, pointers, `overflow` and CYCLE go to 0 immediately.
  - `tx_valid`=0 and `tx_data`=0 immediately.
  - Queued words are discarded.
- `data_from_mem` during reset follows decode with the reset register values: CYCLE reads 0 and STATUS reads 32'h1.
- Reset release: CYCLE reads 1 in the cycle after the first rising edge with `reset`=1.

## Test plan
- RAM write/read:
  - Store 32'hDEAD_BEEF at 0x10, then 0xCAFE_F00D at 0x3FC; read both back → exact values.
  - A read at 0x13 returns DEAD_BEEF.
  - A read at 0x400 (DEPTH 256) returns 0.
- Cycle counter: release reset; read CYCLE on successive cycles → 1, 2, 3. Write 0x55 to CYCLE → no effect on its value.
- FIFO fill and drain:
  - With `tx_ready`=0, push 1, 2, 3, 4 → STATUS=32'h2 and `tx_valid`=1.
  - Push 5 → STATUS=32'h6 and the word 5 is absent.
  - Raise `tx_ready` → `tx_data` sequence 1, 2, 3, 4, then STATUS=32'h5.
  - Write STATUS → STATUS reads 32'h1.
- Full with simultaneous push/pop: with the FIFO full of 1–4 and `tx_ready`=1, push 9 → 1 is popped, 9 is accepted, `overflow` stays 0 and the drain order is 2, 3, 4, 9.
- Reset mid-operation: with 3 words queued and CYCLE≈50, assert `reset`=0 between edges → `tx_valid`=0, STATUS=32'h1 and CYCLE=0 without waiting for a clock edge. RAM contents written before reset read back unchanged.
- Unmapped address: write 0x1234 to MMIO_BASE+0xC → the read returns 0 and no FIFO or RAM state changes.
